// File: rtl/except_ctrl.sv
// MEM-stage exception sequencer for the 5-stage MIPS pipeline.
// Picks the highest-priority exception or interrupt presented in MEM,
// updates the CP0 subset (Status, Cause, EPC, BadVAddr), flushes the
// pipeline for FLUSH_CYCLES cycles, then redirects fetch to the handler
// (or to EPC on ERET) and waits for the fetch unit to accept it.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_excepttype,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [31:0] mem_badvaddr,
  input  logic [5:0]  int_req,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic        pc_ready,
  output logic        flush,
  output logic        stall_req,
  output logic        pc_redirect,
  output logic [31:0] new_pc,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  // Result of prioritisation: whether anything fired, whether it is ERET,
  // whether BadVAddr must be captured, and the ExcCode to record.
  typedef struct packed {
    logic       hit;
    logic       eret;
    logic       badaddr;
    logic [4:0] code;
  } exc_sel_t;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  localparam logic [31:0] STATUS_RST = 32'h0040_0000;
  localparam logic [1:0]  FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Fixed priority, highest first: Int, AdEL, RI, Ov, Tr, Sys, Bp, AdES, ERET.
  // et holds excepttype[15:8]; bit n here is excepttype bit n+8.
  function automatic exc_sel_t prioritise(input logic irq, input logic [7:0] et);
    exc_sel_t s;
    s     = '0;
    s.hit = 1'b1;
    if (irq)        s.code = EXC_INT;
    else if (et[5]) begin s.code = EXC_ADEL; s.badaddr = 1'b1; end
    else if (et[1]) s.code = EXC_RI;
    else if (et[2]) s.code = EXC_OV;
    else if (et[3]) s.code = EXC_TR;
    else if (et[0]) s.code = EXC_SYS;
    else if (et[7]) s.code = EXC_BP;
    else if (et[6]) begin s.code = EXC_ADES; s.badaddr = 1'b1; end
    else if (et[4]) s.eret = 1'b1;
    else            s.hit  = 1'b0;
    return s;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] status_q, cause_q, epc_q, badvaddr_q;
  logic        int_pend;
  logic        take;
  exc_sel_t    sel;

  // Bits outside the defined exception field carry no meaning here.
  logic unused_excepttype;
  assign unused_excepttype = ^{mem_excepttype[31:16], mem_excepttype[7:0]};

  assign int_pend = (|(int_req & status_q[15:10])) & status_q[0] & ~status_q[1] & mem_valid;

  // Decode the winning event for this cycle.
  always_comb begin
    sel = prioritise(int_pend, mem_excepttype[15:8]);
  end

  // Next-state logic; events are only accepted while idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_valid && sel.hit) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
          take    = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == 2'd0) state_d = REDIRECT;
        else               cnt_d   = cnt_q - 2'd1;
      end
      REDIRECT: begin
        if (pc_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered pipeline-control strobes and redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      flush       <= 1'b0;
      stall_req   <= 1'b0;
      pc_redirect <= 1'b0;
      new_pc      <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      flush       <= (state_d == FLUSH);
      stall_req   <= (state_d != IDLE);
      pc_redirect <= (state_d == REDIRECT);
      // ERET returns to the EPC held before this edge.
      if (take) new_pc <= sel.eret ? epc_q : EXC_VECTOR;
    end
  end

  // CP0 registers: MTC0 first, exception capture last so it wins on shared fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= STATUS_RST;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      cause_q[15:10] <= int_req;
      if (cp0_we) begin
        case (cp0_waddr)
          CP0_BADVADDR: badvaddr_q    <= cp0_wdata;
          CP0_STATUS:   status_q      <= cp0_wdata;
          CP0_CAUSE:    cause_q[9:8]  <= cp0_wdata[9:8];
          CP0_EPC:      epc_q         <= cp0_wdata;
          default:      ;
        endcase
      end
      if (take) begin
        if (sel.eret) begin
          status_q[1] <= 1'b0;
        end else begin
          cause_q[6:2] <= sel.code;
          status_q[1]  <= 1'b1;
          // A nested exception (EXL already set) keeps the original EPC and BD.
          if (!status_q[1]) begin
            epc_q       <= mem_in_delayslot ? (mem_pc - 32'd4) : mem_pc;
            cause_q[31] <= mem_in_delayslot;
          end
          if (sel.badaddr) badvaddr_q <= mem_badvaddr;
        end
      end
    end
  end

  assign status_o   = status_q;
  assign cause_o    = cause_q;
  assign epc_o      = epc_q;
  assign badvaddr_o = badvaddr_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: redirect targets go through a scoreboard
// queue, CP0 and strobe values are checked against hand-derived constants.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_excepttype;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic [31:0] mem_badvaddr;
  logic [5:0]  int_req;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        pc_ready;
  logic        flush, stall_req, pc_redirect;
  logic [31:0] new_pc, status_o, cause_o, epc_o, badvaddr_o;

  int nerr = 0;
  int nchk = 0;
  logic [31:0] sb[$];

  localparam logic [31:0] VEC = 32'hBFC00380;

  except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_excepttype(mem_excepttype),
    .mem_pc(mem_pc), .mem_in_delayslot(mem_in_delayslot), .mem_badvaddr(mem_badvaddr),
    .int_req(int_req), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .pc_ready(pc_ready), .flush(flush), .stall_req(stall_req), .pc_redirect(pc_redirect),
    .new_pc(new_pc), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
    .badvaddr_o(badvaddr_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall_req}, 32'd0);
    chk({tag, "_redir"}, {31'd0, pc_redirect}, 32'd0);
    chk({tag, "_newpc"}, new_pc, 32'd0);
    chk({tag, "_status"}, status_o, 32'h0040_0000);
    chk({tag, "_cause"}, cause_o, 32'd0);
    chk({tag, "_epc"}, epc_o, 32'd0);
    chk({tag, "_badv"}, badvaddr_o, 32'd0);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    step();
    cp0_we = 1'b0;
  endtask

  // Present one event for a single cycle and queue its expected redirect target.
  task automatic fire(input logic [31:0] et, input logic [31:0] pc, input logic ds,
                      input logic [31:0] bv, input logic [31:0] target);
    mem_valid = 1'b1; mem_excepttype = et; mem_pc = pc;
    mem_in_delayslot = ds; mem_badvaddr = bv;
    sb.push_back(target);
    step();
    mem_valid = 1'b0; mem_excepttype = 32'd0; mem_in_delayslot = 1'b0;
  endtask

  // Wait (bounded) for the redirect, compare it with the queue head.
  task automatic wait_redirect(input string tag);
    logic [31:0] exp;
    int n;
    n = 0;
    while (!pc_redirect && n < 20) begin
      step();
      n++;
    end
    nchk++;
    assert (pc_redirect === 1'b1) else begin
      nerr++;
      $error("FAIL %s_timeout: observed=%b expected=1", tag, pc_redirect);
    end
    if (sb.size() == 0) begin
      nchk++; nerr++;
      $error("FAIL %s_sb_empty: observed=0 expected=1 entries", tag);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_newpc"}, new_pc, exp);
    end
  endtask

  // Redirect then accept with pc_ready high; strobes must drop next cycle.
  task automatic drain(input string tag);
    wait_redirect(tag);
    step();
    chk({tag, "_idle_redir"}, {31'd0, pc_redirect}, 32'd0);
    chk({tag, "_idle_stall"}, {31'd0, stall_req}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_excepttype = 32'd0; mem_pc = 32'd0;
    mem_in_delayslot = 1'b0; mem_badvaddr = 32'd0; int_req = 6'd0;
    cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'd0; pc_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_reset("rst");

    // Overflow, not in a delay slot, EXL=0
    mtc0(5'd12, 32'd0);
    chk("status_clr", status_o, 32'd0);
    fire(32'h400, 32'h8000_1000, 1'b0, 32'd0, VEC);
    chk("ov_flush", {31'd0, flush}, 32'd1);
    chk("ov_stall", {31'd0, stall_req}, 32'd1);
    chk("ov_redir_t1", {31'd0, pc_redirect}, 32'd0);
    chk("ov_cause", cause_o, 32'h0000_0030);
    chk("ov_epc", epc_o, 32'h8000_1000);
    chk("ov_status", status_o, 32'h0000_0002);
    step();
    chk("ov_redir_t2", {31'd0, pc_redirect}, 32'd1);
    chk("ov_flush_t2", {31'd0, flush}, 32'd0);
    drain("ov");

    // Trap in a delay slot
    mtc0(5'd12, 32'd0);
    fire(32'h800, 32'h8000_2004, 1'b1, 32'd0, VEC);
    chk("tr_epc", epc_o, 32'h8000_2000);
    chk("tr_cause", cause_o, 32'h8000_0034);
    drain("tr");

    // Interrupt beats overflow
    mtc0(5'd12, 32'h0000_0401);
    int_req = 6'd1;
    step();
    fire(32'h400, 32'h8000_4000, 1'b0, 32'd0, VEC);
    int_req = 6'd0;
    chk("int_cause", cause_o, 32'h0000_0400);
    chk("int_epc", epc_o, 32'h8000_4000);
    chk("int_status", status_o, 32'h0000_0403);
    drain("int");

    // Nested trap with EXL=1: EPC and BD untouched
    fire(32'h800, 32'h8000_5000, 1'b1, 32'd0, VEC);
    chk("nest_epc", epc_o, 32'h8000_4000);
    chk("nest_cause", cause_o, 32'h0000_0034);
    drain("nest");

    // ERET with pc_ready held low for three cycles
    mtc0(5'd14, 32'h8000_3000);
    chk("mtc0_epc", epc_o, 32'h8000_3000);
    pc_ready = 1'b0;
    fire(32'h1000, 32'h8000_3333, 1'b0, 32'd0, 32'h8000_3000);
    chk("eret_status", status_o, 32'h0000_0401);
    chk("eret_cause", cause_o, 32'h0000_0034);
    chk("eret_flush", {31'd0, flush}, 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("eret_hold_redir%0d", i), {31'd0, pc_redirect}, 32'd1);
      chk($sformatf("eret_hold_stall%0d", i), {31'd0, stall_req}, 32'd1);
      if (i < 2) step();
    end
    pc_ready = 1'b1;
    drain("eret");

    // MTC0 EPC in the same cycle as RI: exception wins
    cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h0000_1234;
    fire(32'h200, 32'h8000_6000, 1'b0, 32'd0, VEC);
    cp0_we = 1'b0;
    chk("ri_epc", epc_o, 32'h8000_6000);
    chk("ri_cause", cause_o, 32'h0000_0028);
    chk("ri_status", status_o, 32'h0000_0403);
    drain("ri");

    // MTC0 Status in the same cycle as Ov: EXL forced, other bits from MTC0
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h0000_0400;
    fire(32'h400, 32'h8000_7000, 1'b0, 32'd0, VEC);
    cp0_we = 1'b0;
    chk("mtst_status", status_o, 32'h0000_0402);
    chk("mtst_epc", epc_o, 32'h8000_6000);
    drain("mtst");

    // Cause write only reaches the soft-interrupt bits
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("mtc0_cause", cause_o, 32'h0000_0330);

    // Invalid slot and undefined bits must not trigger
    mem_valid = 1'b0; mem_excepttype = 32'h400;
    step();
    chk("bubble_flush", {31'd0, flush}, 32'd0);
    mem_valid = 1'b1; mem_excepttype = 32'h0000_0001;
    step();
    chk("undef_flush", {31'd0, flush}, 32'd0);
    mem_valid = 1'b0; mem_excepttype = 32'd0;

    // AdEL outranks Ov and captures BadVAddr
    fire(32'h2400, 32'h8000_8000, 1'b0, 32'hDEAD_BEEF, VEC);
    chk("adel_cause", cause_o, 32'h0000_0310);
    chk("adel_badv", badvaddr_o, 32'hDEAD_BEEF);
    chk("adel_epc", epc_o, 32'h8000_6000);
    drain("adel");

    // Reset while redirect is pending
    pc_ready = 1'b0;
    fire(32'h100, 32'h8000_9000, 1'b0, 32'd0, VEC);
    wait_redirect("sys");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("midrst");
    pc_ready = 1'b1;

    // Back in IDLE: a breakpoint is accepted normally
    fire(32'h8000, 32'h8000_A000, 1'b0, 32'd0, VEC);
    chk("bp_flush", {31'd0, flush}, 32'd1);
    chk("bp_cause", cause_o, 32'h0000_0024);
    chk("bp_epc", epc_o, 32'h8000_A000);
    chk("bp_status", status_o, 32'h0040_0002);
    drain("bp");

    chk("sb_left", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
